// File: rtl/decode_stage.sv
// Instruction decode stage: splits 32-bit words into R/I/J/FP fields, queues them in a
// 2-entry skid buffer and holds back any head whose source registers have writes pending.
module decode_stage #(
  parameter int IMM_W         = 32,
  parameter bit IMM_SIGN_EXT  = 1'b1,
  parameter bit SCOREBOARD_EN = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_type,
  output logic [4:0]       out_op,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [9:0]       out_shamt,
  output logic [IMM_W-1:0] out_imm,
  output logic [28:0]      out_address,
  output logic [3:0]       out_fp_op,
  output logic [4:0]       out_r0,
  output logic [4:0]       out_f0,
  output logic [4:0]       out_f1,
  output logic [4:0]       out_f2,
  input  logic             wb_valid,
  input  logic             wb_fp,
  input  logic [4:0]       wb_reg,
  output logic             hazard,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [1:0] T_R  = 2'd0;
  localparam logic [1:0] T_I  = 2'd1;
  localparam logic [1:0] T_J  = 2'd2;
  localparam logic [1:0] T_FP = 2'd3;

  typedef struct packed {
    logic [1:0]       itype;
    logic [4:0]       op;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [9:0]       shamt;
    logic [IMM_W-1:0] imm;
    logic [28:0]      address;
    logic [3:0]       fp_op;
    logic [4:0]       r0;
    logic [4:0]       f0;
    logic [4:0]       f1;
    logic [4:0]       f2;
  } entry_t;

  // Fields that do not belong to the instruction's format are stored as zero.
  function automatic entry_t decode(input logic [31:0] w);
    entry_t e;
    e = '0;
    e.itype = w[31:30];
    case (w[31:30])
      T_R: begin
        e.op    = w[29:25];
        e.rs    = w[24:20];
        e.rt    = w[19:15];
        e.rd    = w[14:10];
        e.shamt = w[9:0];
      end
      T_I: begin
        e.op        = w[29:25];
        e.rs        = w[24:20];
        e.rt        = w[19:15];
        e.imm[14:0] = w[14:0];
        for (int i = 15; i < IMM_W; i++) e.imm[i] = IMM_SIGN_EXT & w[14];
      end
      T_J: begin
        e.op      = {4'b0, w[29]};
        e.address = w[28:0];
      end
      default: begin
        e.op    = {1'b0, w[29:26]};
        e.fp_op = w[29:26];
        e.r0    = w[25:21];
        e.f0    = w[20:16];
        e.f1    = w[15:11];
        e.f2    = w[10:6];
      end
    endcase
    return e;
  endfunction

  state_t      state, state_next;
  entry_t      head_q, tail_q, view;
  logic        accept, issue, head_present;
  logic        src_busy, dst_en, dst_fp;
  logic [4:0]  dst_reg;
  logic [31:0] gpr_busy, fp_busy, gpr_busy_next, fp_busy_next;

  assign in_ready     = (state != TWO);
  assign head_present = (state != EMPTY);
  assign accept       = in_valid & in_ready & ~flush;
  assign issue        = out_valid & out_ready;
  assign hazard       = head_present & SCOREBOARD_EN & src_busy;
  assign out_valid    = head_present & ~hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) state_next = ONE;
        ONE: begin
          if (issue && !accept)      state_next = EMPTY;
          else if (accept && !issue) state_next = TWO;
        end
        TWO:     if (issue) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // The head always holds the oldest entry; a new word lands in the head slot only when it is the sole entry left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (!flush) begin
      if (issue) head_q <= tail_q;
      if (accept) begin
        if (state == EMPTY || (state == ONE && issue)) head_q <= decode(in_instr);
        else                                           tail_q <= decode(in_instr);
      end
    end
  end

  always_comb begin
    src_busy = 1'b0;
    dst_en   = 1'b0;
    dst_fp   = 1'b0;
    dst_reg  = '0;
    case (head_q.itype)
      T_R: begin
        src_busy = gpr_busy[head_q.rs] | gpr_busy[head_q.rt];
        dst_en   = 1'b1;
        dst_reg  = head_q.rd;
      end
      T_I: begin
        src_busy = gpr_busy[head_q.rs];
        dst_en   = 1'b1;
        dst_reg  = head_q.rt;
      end
      T_FP: begin
        src_busy = fp_busy[head_q.f1] | fp_busy[head_q.f2];
        dst_en   = 1'b1;
        dst_fp   = 1'b1;
        dst_reg  = head_q.f0;
      end
      default: ;
    endcase
  end

  // Setting is applied after clearing so an issue and a writeback to the same register leave it busy.
  always_comb begin
    gpr_busy_next = gpr_busy;
    fp_busy_next  = fp_busy;
    if (wb_valid) begin
      if (wb_fp) fp_busy_next[wb_reg]  = 1'b0;
      else       gpr_busy_next[wb_reg] = 1'b0;
    end
    if (issue && dst_en && SCOREBOARD_EN) begin
      if (dst_fp) fp_busy_next[dst_reg]  = 1'b1;
      else        gpr_busy_next[dst_reg] = 1'b1;
    end
    gpr_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_busy <= '0;
      fp_busy  <= '0;
    end else begin
      gpr_busy <= gpr_busy_next;
      fp_busy  <= fp_busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     stall_cnt <= '0;
    else if (hazard && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign view        = head_present ? head_q : '0;
  assign out_type    = view.itype;
  assign out_op      = view.op;
  assign out_rs      = view.rs;
  assign out_rt      = view.rt;
  assign out_rd      = view.rd;
  assign out_shamt   = view.shamt;
  assign out_imm     = view.imm;
  assign out_address = view.address;
  assign out_fp_op   = view.fp_op;
  assign out_r0      = view.r0;
  assign out_f0      = view.f0;
  assign out_f1      = view.f1;
  assign out_f2      = view.f2;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random traffic,
// compared every cycle against a queue-based model of the decode/scoreboard rules.
module tb_decode_stage;

  localparam int CNT_W    = 4;
  localparam int ZX_IMM_W = 20;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready, wb_valid, wb_fp;
  logic [4:0]  wb_reg;
  logic [31:0] in_instr;

  logic in_ready, out_valid, hazard;
  logic [1:0] out_type;
  logic [4:0] out_op, out_rs, out_rt, out_rd, out_r0, out_f0, out_f1, out_f2;
  logic [9:0] out_shamt;
  logic [31:0] out_imm;
  logic [28:0] out_address;
  logic [3:0] out_fp_op;
  logic [CNT_W-1:0] stall_cnt;

  logic zx_in_ready, zx_out_valid, zx_hazard;
  logic [1:0] zx_type;
  logic [4:0] zx_op, zx_rs, zx_rt, zx_rd, zx_r0, zx_f0, zx_f1, zx_f2;
  logic [9:0] zx_shamt;
  logic [ZX_IMM_W-1:0] zx_imm;
  logic [28:0] zx_address;
  logic [3:0] zx_fp_op;
  logic [15:0] zx_stall;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  bit gpr_b[32];
  bit fp_b[32];
  int stall_m;
  int stall_z;

  always #5 clk = ~clk;

  decode_stage #(.IMM_W(32), .IMM_SIGN_EXT(1'b1), .SCOREBOARD_EN(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
    .out_imm(out_imm), .out_address(out_address), .out_fp_op(out_fp_op), .out_r0(out_r0),
    .out_f0(out_f0), .out_f1(out_f1), .out_f2(out_f2), .wb_valid(wb_valid), .wb_fp(wb_fp),
    .wb_reg(wb_reg), .hazard(hazard), .stall_cnt(stall_cnt)
  );

  decode_stage #(.IMM_W(ZX_IMM_W), .IMM_SIGN_EXT(1'b0), .SCOREBOARD_EN(1'b1), .CNT_W(16)) dut_zx (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(zx_in_ready),
    .in_instr(in_instr), .out_valid(zx_out_valid), .out_ready(out_ready), .out_type(zx_type),
    .out_op(zx_op), .out_rs(zx_rs), .out_rt(zx_rt), .out_rd(zx_rd), .out_shamt(zx_shamt),
    .out_imm(zx_imm), .out_address(zx_address), .out_fp_op(zx_fp_op), .out_r0(zx_r0),
    .out_f0(zx_f0), .out_f1(zx_f1), .out_f2(zx_f2), .wb_valid(wb_valid), .wb_fp(wb_fp),
    .wb_reg(wb_reg), .hazard(zx_hazard), .stall_cnt(zx_stall)
  );

  function automatic logic [31:0] mk_r(logic [4:0] op, logic [4:0] rs, logic [4:0] rt,
                                       logic [4:0] rd, logic [9:0] sh);
    return {2'b00, op, rs, rt, rd, sh};
  endfunction

  function automatic logic [31:0] mk_i(logic [4:0] op, logic [4:0] rs, logic [4:0] rt, logic [14:0] imm);
    return {2'b01, op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_j(logic b, logic [28:0] addr);
    return {2'b10, b, addr};
  endfunction

  function automatic logic [31:0] mk_fp(logic [3:0] fop, logic [4:0] r0, logic [4:0] f0,
                                        logic [4:0] f1, logic [4:0] f2);
    return {2'b11, fop, r0, f0, f1, f2, 6'h2A};
  endfunction

  function automatic logic [4:0] fld(logic [31:0] w, int lsb);
    return 5'((w >> lsb) & 32'h1F);
  endfunction

  // Source registers of the word, looked up in the model's busy tables.
  function automatic bit src_busy_m(logic [31:0] w);
    case (int'(w >> 30))
      0:       return gpr_b[fld(w, 20)] || gpr_b[fld(w, 15)];
      1:       return gpr_b[fld(w, 20)];
      3:       return fp_b[fld(w, 11)] || fp_b[fld(w, 6)];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 3))
      0: return mk_r(5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 10'($urandom));
      1: return mk_i(5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 15'($urandom));
      2: return mk_j(1'($urandom), 29'($urandom));
      default: return mk_fp(4'($urandom), 5'($urandom), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) begin
      gpr_b[i] = 1'b0;
      fp_b[i]  = 1'b0;
    end
    stall_m = 0;
    stall_z = 0;
  endtask

  task automatic checkOutput(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(string ph);
    logic [31:0] w;
    bit present, hz;
    logic [1:0] e_type;
    logic [4:0] e_op, e_rs, e_rt, e_rd, e_r0, e_f0, e_f1, e_f2;
    logic [9:0] e_sh;
    logic [31:0] e_imm;
    logic [ZX_IMM_W-1:0] e_zimm;
    logic [28:0] e_addr;
    logic [3:0] e_fpop;
    int v;
    present = (q.size() > 0);
    w = present ? q[0] : 32'h0;
    e_type = '0; e_op = '0; e_rs = '0; e_rt = '0; e_rd = '0; e_sh = '0; e_imm = '0; e_zimm = '0;
    e_addr = '0; e_fpop = '0; e_r0 = '0; e_f0 = '0; e_f1 = '0; e_f2 = '0;
    if (present) begin
      e_type = 2'(w >> 30);
      case (int'(w >> 30))
        0: begin
          e_op = fld(w, 25); e_rs = fld(w, 20); e_rt = fld(w, 15); e_rd = fld(w, 10);
          e_sh = 10'(w % 1024);
        end
        1: begin
          e_op = fld(w, 25); e_rs = fld(w, 20); e_rt = fld(w, 15);
          v = int'(w % 32768);
          e_zimm = ZX_IMM_W'(v);
          if (v >= 16384) v = v - 32768;
          e_imm = 32'(v);
        end
        2: begin
          e_op = 5'((w >> 29) & 1);
          e_addr = 29'(w % (32'h1 << 29));
        end
        default: begin
          e_fpop = 4'((w >> 26) & 15); e_op = {1'b0, e_fpop};
          e_r0 = fld(w, 21); e_f0 = fld(w, 16); e_f1 = fld(w, 11); e_f2 = fld(w, 6);
        end
      endcase
    end
    hz = present && src_busy_m(w);
    checkOutput({ph, "/in_ready"}, in_ready, q.size() != 2);
    checkOutput({ph, "/out_valid"}, out_valid, present && !hz);
    checkOutput({ph, "/hazard"}, hazard, hz);
    checkOutput({ph, "/stall_cnt"}, stall_cnt, stall_m);
    checkOutput({ph, "/out_type"}, out_type, e_type);
    checkOutput({ph, "/out_op"}, out_op, e_op);
    checkOutput({ph, "/out_rs"}, out_rs, e_rs);
    checkOutput({ph, "/out_rt"}, out_rt, e_rt);
    checkOutput({ph, "/out_rd"}, out_rd, e_rd);
    checkOutput({ph, "/out_shamt"}, out_shamt, e_sh);
    checkOutput({ph, "/out_imm"}, out_imm, e_imm);
    checkOutput({ph, "/out_address"}, out_address, e_addr);
    checkOutput({ph, "/out_fp_op"}, out_fp_op, e_fpop);
    checkOutput({ph, "/out_fp_regs"}, {out_r0, out_f0, out_f1, out_f2}, {e_r0, e_f0, e_f1, e_f2});
    checkOutput({ph, "/zx_imm"}, zx_imm, e_zimm);
    checkOutput({ph, "/zx_ctrl"}, {zx_in_ready, zx_out_valid, zx_hazard, zx_stall},
                {q.size() != 2, present && !hz, hz, 16'(stall_z)});
    checkOutput({ph, "/zx_fields"},
                {zx_type, zx_op, zx_rs, zx_rt, zx_rd, zx_shamt, zx_address, zx_fp_op, zx_r0, zx_f0, zx_f1, zx_f2},
                {e_type, e_op, e_rs, e_rt, e_rd, e_sh, e_addr, e_fpop, e_r0, e_f0, e_f1, e_f2});
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit present, hz, iss, acc;
    logic [31:0] w;
    present = (q.size() > 0);
    w = present ? q[0] : 32'h0;
    hz  = present && src_busy_m(w);
    iss = present && !hz && out_ready;
    acc = in_valid && (q.size() != 2) && !flush;
    if (hz && stall_m < (1 << CNT_W) - 1) stall_m++;
    if (hz && stall_z < 65535) stall_z++;
    if (wb_valid) begin
      if (wb_fp) fp_b[wb_reg] = 1'b0;
      else       gpr_b[wb_reg] = 1'b0;
    end
    if (iss) begin
      case (int'(w >> 30))
        0: if (fld(w, 10) != 0) gpr_b[fld(w, 10)] = 1'b1;
        1: if (fld(w, 15) != 0) gpr_b[fld(w, 15)] = 1'b1;
        3: fp_b[fld(w, 16)] = 1'b1;
        default: ;
      endcase
    end
    if (flush) begin
      q.delete();
    end else begin
      if (iss) void'(q.pop_front());
      if (acc) q.push_back(in_instr);
    end
  endtask

  task automatic applyStimulus(bit v, logic [31:0] w, bit ordy, bit fl, bit wbv, bit wbf,
                               logic [4:0] wbr, string ph);
    in_valid  = v;
    in_instr  = w;
    out_ready = ordy;
    flush     = fl;
    wb_valid  = wbv;
    wb_fp     = wbf;
    wb_reg    = wbr;
    @(negedge clk);
    checkAll(ph);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, bit ordy, string ph);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, ordy, 1'b0, 1'b0, 1'b0, 5'd0, ph);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_fp = 1'b0; wb_reg = '0; in_instr = '0;
    model_reset();
    #12;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1, 32'h0042_1C05, 1, 0, 0, 0, 5'd0, "r_accept");
    applyStimulus(0, 32'h0, 1, 0, 0, 0, 5'd0, "r_issue");
    applyStimulus(0, 32'h0, 1, 0, 1, 0, 5'd7, "wb7");

    applyStimulus(1, mk_i(5'd3, 5'd1, 5'd2, 15'h7FFF), 1, 0, 0, 0, 5'd0, "i_neg_accept");
    applyStimulus(0, 32'h0, 1, 0, 0, 0, 5'd0, "i_neg_issue");
    applyStimulus(1, mk_i(5'd4, 5'd6, 5'd0, 15'h0123), 1, 0, 1, 0, 5'd2, "i_pos_accept");
    applyStimulus(0, 32'h0, 1, 0, 0, 0, 5'd0, "i_pos_issue");
    applyStimulus(1, mk_j(1'b1, 29'h1ABC_DEF0), 1, 0, 0, 0, 5'd0, "j_accept");
    applyStimulus(0, 32'h0, 1, 0, 0, 0, 5'd0, "j_issue");

    applyStimulus(1, mk_r(5'd0, 5'd1, 5'd1, 5'd5, 10'd0), 1, 0, 0, 0, 5'd0, "w5_accept");
    applyStimulus(1, mk_r(5'd0, 5'd5, 5'd0, 5'd8, 10'd0), 1, 0, 0, 0, 5'd0, "dep5_accept");
    idle(4, 1'b1, "hazard5_hold");
    applyStimulus(0, 32'h0, 1, 0, 1, 0, 5'd5, "wb5");
    applyStimulus(0, 32'h0, 1, 0, 0, 0, 5'd0, "after_wb5");
    applyStimulus(0, 32'h0, 1, 0, 1, 0, 5'd8, "wb8");

    applyStimulus(1, mk_j(1'b0, 29'h11), 0, 0, 0, 0, 5'd0, "bp1");
    applyStimulus(1, mk_j(1'b1, 29'h22), 0, 0, 0, 0, 5'd0, "bp2");
    applyStimulus(1, mk_j(1'b0, 29'h33), 0, 0, 0, 0, 5'd0, "bp3_blocked");
    applyStimulus(1, mk_j(1'b0, 29'h33), 1, 0, 0, 0, 5'd0, "bp_release");
    applyStimulus(1, mk_j(1'b0, 29'h33), 1, 0, 0, 0, 5'd0, "bp3_accept");
    idle(3, 1'b1, "bp_drain");

    applyStimulus(1, mk_fp(4'd2, 5'd1, 5'd0, 5'd3, 5'd4), 1, 0, 0, 0, 5'd0, "fp_w0");
    applyStimulus(1, mk_fp(4'd5, 5'd2, 5'd6, 5'd0, 5'd7), 1, 0, 0, 0, 5'd0, "fp_r0_accept");
    idle(3, 1'b1, "fp_hazard_hold");
    applyStimulus(0, 32'h0, 1, 0, 1, 1, 5'd0, "wb_f0");
    applyStimulus(0, 32'h0, 1, 0, 0, 0, 5'd0, "fp_r0_issue");
    applyStimulus(0, 32'h0, 1, 0, 1, 1, 5'd6, "wb_f6");

    applyStimulus(1, mk_r(5'd1, 5'd2, 5'd3, 5'd0, 10'd4), 1, 0, 0, 0, 5'd0, "r_w0");
    applyStimulus(1, mk_r(5'd2, 5'd0, 5'd0, 5'd9, 10'd1), 1, 0, 0, 0, 5'd0, "r_r0");
    applyStimulus(0, 32'h0, 1, 0, 0, 0, 5'd0, "r_r0_issue");

    applyStimulus(1, mk_j(1'b0, 29'h55), 0, 0, 0, 0, 5'd0, "fl_q1");
    applyStimulus(1, mk_i(5'd0, 5'd9, 5'd10, 15'h4000), 0, 0, 0, 0, 5'd0, "fl_q2");
    applyStimulus(1, mk_j(1'b1, 29'h66), 0, 1, 0, 0, 5'd0, "flush");
    applyStimulus(1, mk_r(5'd0, 5'd9, 5'd0, 5'd1, 10'd0), 0, 0, 0, 0, 5'd0, "post_flush_dep9");
    idle(18, 1'b1, "stall_saturate");
    applyStimulus(0, 32'h0, 1, 0, 1, 0, 5'd9, "wb9");
    idle(2, 1'b1, "after_wb9");

    applyStimulus(1, mk_fp(4'd1, 5'd1, 5'd2, 5'd3, 5'd4), 0, 0, 0, 0, 5'd0, "pre_reset");
    rst_n = 1'b0;
    #2;
    model_reset();
    checkAll("async_reset");
    in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), rand_instr(), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, 1'($urandom),
                    5'($urandom_range(0, 7)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
